au_normalize_pipe: RTL and testbench

Pipelined normalizer that sits directly downstream of the leading-zero detector stage.
- Takes an unsigned word, finds the position of its leading '1', encodes it as a leading-zero count, and left-shifts the word so that its MSB is '1'.
- Feeds mantissa-alignment and FP-pack logic in the arithmetic-unit library.
- Valid/ready streaming interface with a fixed two-stage pipeline and full throughput.

---
 rtl/au_normalize_pipe.sv | 116 +++++++++++
 tb/tb_au_normalize_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/au_normalize_pipe.sv
// Two-stage normalizer: S1 captures the word and its one-hot leading-'1' vector,
// S2 encodes the leading-zero count and left-shifts the word so its MSB is '1'.
module au_normalize_pipe #(
    parameter int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    generate
        if (WIDTH < 2) begin : g_width_check
            $fatal(1, "au_normalize_pipe: WIDTH must be >= 2");
        end
    endgenerate

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic [WIDTH-1:0] r_s1_onehot;
    logic             r_s1_zero;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_y;
    logic [CNT_W-1:0] r_cnt;
    logic             r_zero;

    logic             w_s2_adv;
    logic             w_in_acc;
    logic [WIDTH-1:0] w_onehot;
    logic [CNT_W-1:0] w_enc;
    logic [CNT_W-1:0] w_cnt;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_y;

    // Handshake: a word moves on any cycle with valid & ready. S2 refills whenever
    // it is empty or draining; S1 accepts whenever it is empty or advancing.
    assign w_s2_adv  = r_s1_valid & (~r_s2_valid | out_ready);
    assign in_ready  = ~r_s1_valid | w_s2_adv;
    assign w_in_acc  = in_valid & in_ready;
    assign out_valid = r_s2_valid;
    assign y         = r_y;
    assign cnt       = r_cnt;
    assign zero      = r_zero;

    // Bit i survives only if every bit above it is clear.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_onehot
            assign w_onehot[gi] = a[gi] & ~|(a >> (gi + 1));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_onehot <= '0;
            r_s1_zero   <= 1'b0;
        end else if (w_in_acc) begin
            r_s1_valid  <= 1'b1;
            r_s1_data   <= a;
            r_s1_onehot <= w_onehot;
            r_s1_zero   <= ~|a;
        end else if (w_s2_adv) begin
            r_s1_valid  <= 1'b0;
        end
    end

    always_comb begin
        w_enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_s1_onehot[i]) begin
                w_enc = w_enc | CNT_W'(WIDTH - 1 - i);
            end
        end
    end

    assign w_cnt = r_s1_zero ? CNT_W'(WIDTH) : w_enc;

    // Logarithmic barrel shifter: stage k shifts by 2**k when count bit k is set.
    always_comb begin
        w_shift = r_s1_data;
        for (int k = 0; k < CNT_W; k++) begin
            if (w_cnt[k]) begin
                w_shift = w_shift << (1 << k);
            end
        end
    end

    assign w_y = r_s1_zero ? '0 : w_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_y        <= '0;
            r_cnt      <= '0;
            r_zero     <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= 1'b1;
            r_y        <= w_y;
            r_cnt      <= w_cnt;
            r_zero     <= r_s1_zero;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_au_normalize_pipe.sv
// Self-checking bench for au_normalize_pipe: directed vector table, backpressure,
// mid-stream reset, back-to-back throughput and random stress against a lzc model.
module tb_au_normalize_pipe;

    localparam int W  = 16;
    localparam int CW = 5;
    localparam int EW = 1 + CW + W;

    typedef struct packed {
        logic [W-1:0]  a;
        logic [W-1:0]  y;
        logic [CW-1:0] cnt;
        logic          zero;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  y;
    logic [CW-1:0] cnt;
    logic          zero;

    int checks = 0;
    int errors = 0;
    int n_pop  = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] held;
    logic          prev_stall = 1'b0;

    au_normalize_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .cnt       (cnt),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference: a nonzero word has clog2(a+1) significant bits; the rest are leading zeros.
    function automatic logic [EW-1:0] model(input logic [W-1:0] av);
        int          nbits;
        int          c;
        int unsigned yy;
        nbits = (av == '0) ? 0 : $clog2(int'(av) + 1);
        c     = W - nbits;
        yy    = (av == '0) ? 0 : (int'(av) << c);
        return {av == '0, CW'(c), W'(yy)};
    endfunction

    task automatic chk(input logic ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: inputs and outputs are sampled on the falling edge, where the
    // handshake seen is exactly what the next rising edge will transfer.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk(out_valid === 1'b1, "stall_valid", 32'(out_valid), 32'd1);
                chk({zero, cnt, y} === held, "stall_hold", 32'({zero, cnt, y}), 32'(held));
            end
            if (out_valid && out_ready) begin
                chk(exp_q.size() != 0, "queue_nonempty", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    chk({zero, cnt, y} === e, "result", 32'({zero, cnt, y}), 32'(e));
                    n_pop++;
                end
            end
            prev_stall = out_valid && !out_ready;
            held       = {zero, cnt, y};
            if (in_valid && in_ready) exp_q.push_back(model(a));
        end
    end

    // Word presented in the cycle starting at edge N, captured at N+1, visible after N+2.
    task automatic send_single(input vec_t v, input string nm);
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = v.a;
        @(negedge clk);
        chk(in_ready === 1'b1, {nm, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        @(negedge clk);
        chk(out_valid === 1'b0, {nm, "_early"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk(out_valid === 1'b1, {nm, "_valid"}, 32'(out_valid), 32'd1);
        chk(y === v.y, {nm, "_y"}, 32'(y), 32'(v.y));
        chk(cnt === v.cnt, {nm, "_cnt"}, 32'(cnt), 32'(v.cnt));
        chk(zero === v.zero, {nm, "_zero"}, 32'(zero), 32'(v.zero));
    endtask

    task automatic present(input logic v, input logic [W-1:0] av, input logic rdy);
        @(posedge clk); #1;
        in_valid  = v;
        a         = av;
        out_ready = rdy;
        @(negedge clk);
    endtask

    vec_t tbl[8];

    initial begin
        int base;
        int got_n;
        logic [CW-1:0] got[3];
        logic [W-1:0] bp_words[3];

        tbl[0] = '{16'h0001, 16'h8000, 5'd15, 1'b0};
        tbl[1] = '{16'h8000, 16'h8000, 5'd0,  1'b0};
        tbl[2] = '{16'h0A30, 16'hA300, 5'd4,  1'b0};
        tbl[3] = '{16'h0000, 16'h0000, 5'd16, 1'b1};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 5'd0,  1'b0};
        tbl[5] = '{16'h00F0, 16'hF000, 5'd8,  1'b0};
        tbl[6] = '{16'h0100, 16'h8000, 5'd7,  1'b0};
        tbl[7] = '{16'h4000, 16'h8000, 5'd1,  1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(out_valid === 1'b0, "reset_out_valid", 32'(out_valid), 32'd0);
        chk(y === '0, "reset_y", 32'(y), 32'd0);
        chk(cnt === '0, "reset_cnt", 32'(cnt), 32'd0);
        chk(zero === 1'b0, "reset_zero", 32'(zero), 32'd0);
        chk(in_ready === 1'b1, "reset_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            send_single(tbl[i], $sformatf("vec%0d", i));
            present(1'b0, '0, 1'b1);
        end

        // Back-to-back throughput.
        base = n_pop;
        for (int i = 0; i < 100; i++) begin
            present(1'b1, W'($urandom), 1'b1);
            chk(in_ready === 1'b1, "tput_in_ready", 32'(in_ready), 32'd1);
        end
        for (int i = 0; i < 4; i++) present(1'b0, '0, 1'b1);
        chk(n_pop - base == 100, "tput_count", 32'(n_pop - base), 32'd100);

        // Backpressure: third word must wait while both stages are full.
        bp_words[0] = 16'h00F0;
        bp_words[1] = 16'h0100;
        bp_words[2] = 16'h4000;
        present(1'b1, bp_words[0], 1'b0);
        chk(in_ready === 1'b1, "bp_acc0", 32'(in_ready), 32'd1);
        present(1'b1, bp_words[1], 1'b0);
        chk(in_ready === 1'b1, "bp_acc1", 32'(in_ready), 32'd1);
        for (int c = 0; c < 5; c++) begin
            present(1'b1, bp_words[2], 1'b0);
            chk(in_ready === 1'b0, "bp_in_ready", 32'(in_ready), 32'd0);
            chk(out_valid === 1'b1, "bp_out_valid", 32'(out_valid), 32'd1);
            chk(y === 16'hF000, "bp_y", 32'(y), 32'hF000);
            chk(cnt === 5'd8, "bp_cnt", 32'(cnt), 32'd8);
        end
        got_n = 0;
        present(1'b1, bp_words[2], 1'b1);
        chk(in_ready === 1'b1, "bp_release_accept", 32'(in_ready), 32'd1);
        for (int c = 0; c < 10; c++) begin
            if (out_valid && out_ready && got_n < 3) begin
                got[got_n] = cnt;
                got_n++;
            end
            present(1'b0, '0, 1'b1);
        end
        chk(got_n == 3, "bp_results", 32'(got_n), 32'd3);
        if (got_n == 3) begin
            chk(got[0] === 5'd8, "bp_cnt0", 32'(got[0]), 32'd8);
            chk(got[1] === 5'd7, "bp_cnt1", 32'(got[1]), 32'd7);
            chk(got[2] === 5'd1, "bp_cnt2", 32'(got[2]), 32'd1);
        end

        // Reset with both stages full.
        present(1'b1, 16'h1234, 1'b0);
        present(1'b1, 16'h0010, 1'b0);
        present(1'b0, '0, 1'b0);
        chk(out_valid === 1'b1 && in_ready === 1'b0, "rst_full", 32'({out_valid, in_ready}), 32'b10);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk(out_valid === 1'b0, "rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk(y === '0, "rst_mid_y", 32'(y), 32'd0);
        chk(cnt === '0, "rst_mid_cnt", 32'(cnt), 32'd0);
        chk(zero === 1'b0, "rst_mid_zero", 32'(zero), 32'd0);
        chk(in_ready === 1'b1, "rst_mid_in_ready", 32'(in_ready), 32'd1);
        send_single('{16'h0002, 16'h8000, 5'd14, 1'b0}, "after_rst");
        present(1'b0, '0, 1'b1);

        // Random stress; scoreboard handles ordering, values and stall stability.
        for (int c = 0; c < 10000; c++) begin
            logic [W-1:0] av;
            av = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
            present($urandom_range(0, 9) < 7, av, $urandom_range(0, 9) < 6);
        end
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) present(1'b0, '0, 1'b1);
        chk(exp_q.size() == 0, "drain_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
